// File: rtl/irig_encoder.sv
// IRIG-B DC level-shift time-code generator.
// Keeps the time of the next frame, emits one 100-bit frame per second on irigb and
// a one-clock pps strobe on the rising edge of each frame's reference marker (bit 0).
module irig_encoder #(
    parameter int unsigned CLKS_PER_MS = 10000
) (
    input  logic       clk_10mhz,
    input  logic       rst,
    input  logic       enable,
    input  logic       load,
    input  logic [5:0] ld_sec,
    input  logic [5:0] ld_min,
    input  logic [4:0] ld_hour,
    input  logic [8:0] ld_day,
    input  logic [6:0] ld_year,
    output logic       load_err,
    output logic       irigb,
    output logic       pps,
    output logic       active,
    output logic [6:0] bit_idx
);

    localparam int unsigned BIT_CLKS = 10 * CLKS_PER_MS;
    localparam int unsigned CW       = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] W_ZERO   = CW'(2 * CLKS_PER_MS);
    localparam logic [CW-1:0] W_ONE    = CW'(5 * CLKS_PER_MS);
    localparam logic [CW-1:0] W_MARK   = CW'(8 * CLKS_PER_MS);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [6:0] year;
        logic [8:0] day;
        logic [4:0] hour;
        logic [5:0] mins;
        logic [5:0] sec;
    } tod_t;

    localparam tod_t RESET_TOD = '{year: 7'd0, day: 9'd1, hour: 5'd0, mins: 6'd0, sec: 6'd0};

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      bit_q, bit_d;
    logic            irigb_q, irigb_d;
    logic            pps_q, pps_d;
    logic            load_err_q;
    tod_t            time_q;
    tod_t            frame_q;
    logic            start;
    logic            ld_valid;
    tod_t            ld_t;
    tod_t            snap;
    logic [99:0]     data_bits;

    // Advance a time-of-year value by one second with full calendar rollover.
    function automatic tod_t tod_inc(input tod_t t);
        tod_t r;
        r = t;
        if (t.sec != 6'd59) begin
            r.sec = t.sec + 6'd1;
        end else begin
            r.sec = '0;
            if (t.mins != 6'd59) begin
                r.mins = t.mins + 6'd1;
            end else begin
                r.mins = '0;
                if (t.hour != 5'd23) begin
                    r.hour = t.hour + 5'd1;
                end else begin
                    r.hour = '0;
                    if (t.day < ((t.year[1:0] == 2'b00) ? 9'd366 : 9'd365)) begin
                        r.day = t.day + 9'd1;
                    end else begin
                        r.day  = 9'd1;
                        r.year = (t.year >= 7'd99) ? '0 : t.year + 7'd1;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] d_ones(input logic [8:0] v);
        return 4'(v % 9'd10);
    endfunction

    function automatic logic [3:0] d_tens(input logic [8:0] v);
        return 4'((v / 9'd10) % 9'd10);
    endfunction

    function automatic logic [3:0] d_hund(input logic [8:0] v);
        return 4'(v / 9'd100);
    endfunction

    // High time of a bit: position markers are fixed, data bits come from the frame map.
    function automatic logic [CW-1:0] bit_width(input logic [6:0] b, input logic [99:0] db);
        if (b == 7'd0 || (b % 7'd10) == 7'd9) return W_MARK;
        else if (db[b])                        return W_ONE;
        else                                   return W_ZERO;
    endfunction

    assign ld_t = {ld_year, ld_day, ld_hour, ld_min, ld_sec};

    // Range-check a load request against the calendar of its own year.
    always_comb begin
        ld_valid = (ld_sec <= 6'd59) && (ld_min <= 6'd59) && (ld_hour <= 5'd23) &&
                   (ld_day != 9'd0) && (ld_day <= 9'd366) && (ld_year <= 7'd99) &&
                   !((ld_day == 9'd366) && (ld_year[1:0] != 2'b00));
        snap = (load && ld_valid) ? ld_t : time_q;
    end

    // BCD data bits of the frame being transmitted, LSB first within each digit.
    always_comb begin
        data_bits        = '0;
        data_bits[4:1]   = d_ones(9'(frame_q.sec));
        data_bits[8:6]   = 3'(d_tens(9'(frame_q.sec)));
        data_bits[13:10] = d_ones(9'(frame_q.mins));
        data_bits[17:15] = 3'(d_tens(9'(frame_q.mins)));
        data_bits[23:20] = d_ones(9'(frame_q.hour));
        data_bits[26:25] = 2'(d_tens(9'(frame_q.hour)));
        data_bits[33:30] = d_ones(frame_q.day);
        data_bits[38:35] = d_tens(frame_q.day);
        data_bits[41:40] = 2'(d_hund(frame_q.day));
        data_bits[53:50] = d_ones(9'(frame_q.year));
        data_bits[58:55] = d_tens(9'(frame_q.year));
    end

    // Next-state logic: bit timing, frame sequencing and the registered output levels.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    bit_d   = '0;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 7'd99) begin
                        bit_d = '0;
                        if (enable) start = 1'b1;
                        else        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 7'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are computed from the next counter values so they switch on the same edge.
        irigb_d = (state_d == RUN) && (cnt_d < bit_width(bit_d, data_bits));
        pps_d   = start;
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk_10mhz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            irigb_q <= 1'b0;
            pps_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            irigb_q <= irigb_d;
            pps_q   <= pps_d;
        end
    end

    // Time-of-next-frame register, frame snapshot at frame start, and load handling.
    always_ff @(posedge clk_10mhz or posedge rst) begin
        if (rst) begin
            time_q     <= RESET_TOD;
            frame_q    <= RESET_TOD;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load && !ld_valid;
            if (start) begin
                frame_q <= snap;
                time_q  <= tod_inc(snap);
            end else if (load && ld_valid) begin
                time_q <= ld_t;
            end
        end
    end

    assign irigb    = irigb_q;
    assign pps      = pps_q;
    assign active   = (state_q == RUN);
    assign bit_idx  = bit_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_irig_encoder.sv
// Self-checking bench for irig_encoder: decodes every transmitted bit by measuring its
// high time and compares against frames queued by the stimulus-side time model.
module tb_irig_encoder;

    localparam int unsigned CPM = 10;
    localparam int EV_LOAD = 1;
    localparam int EV_DROP = 2;
    localparam int EV_RST  = 3;

    logic       clk_10mhz = 1'b0;
    logic       rst;
    logic       enable;
    logic       load;
    logic [5:0] ld_sec;
    logic [5:0] ld_min;
    logic [4:0] ld_hour;
    logic [8:0] ld_day;
    logic [6:0] ld_year;
    logic       load_err;
    logic       irigb;
    logic       pps;
    logic       active;
    logic [6:0] bit_idx;

    irig_encoder #(.CLKS_PER_MS(CPM)) dut (
        .clk_10mhz(clk_10mhz),
        .rst      (rst),
        .enable   (enable),
        .load     (load),
        .ld_sec   (ld_sec),
        .ld_min   (ld_min),
        .ld_hour  (ld_hour),
        .ld_day   (ld_day),
        .ld_year  (ld_year),
        .load_err (load_err),
        .irigb    (irigb),
        .pps      (pps),
        .active   (active),
        .bit_idx  (bit_idx)
    );

    always #5 clk_10mhz = ~clk_10mhz;

    typedef struct {int sec; int mins; int hour; int day; int year;} tt_t;
    typedef struct {int k; int c; int kind; tt_t t; int err;} ev_t;

    tt_t exp_q[$];
    ev_t ev_q[$];
    tt_t nxt;
    int  n_chk      = 0;
    int  n_fail     = 0;
    int  ld_pend    = 0;
    int  ld_err_exp = 0;

    function automatic tt_t mk(int h, int m, int s, int d, int y);
        tt_t t;
        t.hour = h; t.mins = m; t.sec = s; t.day = d; t.year = y;
        return t;
    endfunction

    function automatic tt_t tnext(tt_t t);
        tt_t r = t;
        int ndays = (t.year % 4 == 0) ? 366 : 365;
        r.sec++;
        if (r.sec == 60)   begin r.sec = 0;  r.mins++; end
        if (r.mins == 60)  begin r.mins = 0; r.hour++; end
        if (r.hour == 24)  begin r.hour = 0; r.day++;  end
        if (r.day > ndays) begin r.day = 1;  r.year++; end
        if (r.year == 100) r.year = 0;
        return r;
    endfunction

    function automatic logic [99:0] put(logic [99:0] b, int pos, int n, int d);
        logic [99:0] r = b;
        for (int i = 0; i < n; i++) r[pos+i] = ((d >> i) & 1) != 0;
        return r;
    endfunction

    function automatic logic [99:0] tbits(tt_t t);
        logic [99:0] b = '0;
        b = put(b, 1, 4, t.sec % 10);
        b = put(b, 6, 3, t.sec / 10);
        b = put(b, 10, 4, t.mins % 10);
        b = put(b, 15, 3, t.mins / 10);
        b = put(b, 20, 4, t.hour % 10);
        b = put(b, 25, 2, t.hour / 10);
        b = put(b, 30, 4, t.day % 10);
        b = put(b, 35, 4, (t.day / 10) % 10);
        b = put(b, 40, 2, t.day / 100);
        b = put(b, 50, 4, t.year % 10);
        b = put(b, 55, 4, t.year / 10);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock step, sampled on the falling edge; retires any pending load strobe.
    task automatic tick();
        @(negedge clk_10mhz);
        if (ld_pend == 2) begin
            chk("load_err_pulse", 32'(load_err), 32'(ld_err_exp));
            load    = 1'b0;
            ld_pend = 1;
        end else if (ld_pend == 1) begin
            chk("load_err_clear", 32'(load_err), 32'd0);
            ld_pend = 0;
        end
    endtask

    task automatic add_ev(int k, int c, int kind, tt_t t, int err);
        ev_t e;
        e.k = k; e.c = c; e.kind = kind; e.t = t; e.err = err;
        ev_q.push_back(e);
    endtask

    task automatic start_frame();
        exp_q.push_back(nxt);
        nxt = tnext(nxt);
    endtask

    task automatic run_frame(input int nbits);
        int          waited = 0;
        int          bad    = 0;
        int          hi;
        int          ew;
        tt_t         t;
        logic [99:0] fb;
        ev_t         e;
        while (pps !== 1'b1 && waited < 3) begin
            tick();
            waited++;
        end
        chk("pps_latency", 32'(waited), 32'd1);
        if (pps !== 1'b1 || exp_q.size() == 0) return;
        t  = exp_q.pop_front();
        fb = tbits(t);
        for (int k = 0; k < nbits; k++) begin
            hi = 0;
            for (int c = 0; c < 100; c++) begin
                if (!(k == 0 && c == 0)) tick();
                if (irigb === 1'b1) hi++;
                if (pps !== ((k == 0 && c == 0) ? 1'b1 : 1'b0)) bad++;
                if (active !== 1'b1) bad++;
                if (c == 0 && bit_idx !== 7'(k)) bad++;
                if (ev_q.size() != 0 && ev_q[0].k == k && ev_q[0].c == c) begin
                    e = ev_q.pop_front();
                    if (e.kind == EV_LOAD) begin
                        ld_sec  = 6'(e.t.sec);
                        ld_min  = 6'(e.t.mins);
                        ld_hour = 5'(e.t.hour);
                        ld_day  = 9'(e.t.day);
                        ld_year = 7'(e.t.year);
                        load    = 1'b1;
                        ld_pend = 2;
                        ld_err_exp = e.err;
                        if (e.err == 0) nxt = e.t;
                    end else if (e.kind == EV_DROP) begin
                        enable = 1'b0;
                    end else begin
                        chk("pre_rst_high", 32'(irigb), 32'd1);
                        #2 rst = 1'b1;
                        #1;
                        chk("rst_irigb", 32'(irigb), 32'd0);
                        chk("rst_pps", 32'(pps), 32'd0);
                        chk("rst_active", 32'(active), 32'd0);
                        chk("rst_bit_idx", 32'(bit_idx), 32'd0);
                        chk("frame_aux", 32'(bad), 32'd0);
                        return;
                    end
                end
            end
            ew = (k == 0 || k % 10 == 9) ? 8 * CPM : (fb[k] ? 5 * CPM : 2 * CPM);
            chk($sformatf("bit%0d_%0d:%0d:%0d_d%0d_y%0d", k, t.hour, t.mins, t.sec, t.day, t.year),
                32'(hi), 32'(ew));
        end
        chk("frame_aux", 32'(bad), 32'd0);
    endtask

    initial begin
        int bad;
        rst = 1'b1; enable = 1'b0; load = 1'b0;
        ld_sec = '0; ld_min = '0; ld_hour = '0; ld_day = '0; ld_year = '0;
        nxt = mk(0, 0, 0, 1, 0);
        repeat (3) tick();
        chk("reset_irigb", 32'(irigb), 32'd0);
        chk("reset_pps", 32'(pps), 32'd0);
        chk("reset_active", 32'(active), 32'd0);
        chk("reset_bit_idx", 32'(bit_idx), 32'd0);
        chk("reset_load_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        chk("idle_irigb", 32'(irigb), 32'd0);
        chk("idle_active", 32'(active), 32'd0);

        // Frame 1: reset time; one valid load then three rejected loads.
        add_ev(10, 10, EV_LOAD, mk(12, 34, 56, 123, 24), 0);
        add_ev(20, 10, EV_LOAD, mk(12, 34, 60, 123, 24), 1);
        add_ev(30, 10, EV_LOAD, mk(1, 2, 3, 366, 23), 1);
        add_ev(40, 10, EV_LOAD, mk(1, 2, 3, 0, 24), 1);
        enable = 1'b1;
        start_frame(); run_frame(100);

        // Frame 2: 12:34:56 d123 y24; load lands exactly on the next frame start.
        add_ev(99, 99, EV_LOAD, mk(23, 59, 59, 365, 23), 0);
        start_frame(); run_frame(100);

        // Frames 3/4: non-leap year end rollover.
        start_frame(); run_frame(100);
        add_ev(50, 10, EV_LOAD, mk(23, 59, 59, 365, 24), 0);
        start_frame(); run_frame(100);

        // Frames 5/6: leap year reaches day 366; then drop enable mid-frame.
        start_frame(); run_frame(100);
        add_ev(10, 10, EV_LOAD, mk(23, 59, 59, 366, 24), 0);
        add_ev(40, 10, EV_DROP, mk(0, 0, 0, 0, 0), 0);
        start_frame(); run_frame(100);

        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (irigb !== 1'b0 || pps !== 1'b0 || active !== 1'b0 || bit_idx !== 7'd0) bad++;
        end
        chk("idle_after_drop", 32'(bad), 32'd0);

        // Frames 7/8: restart, day 366 rollover into the next year, reset mid-bit.
        enable = 1'b1;
        start_frame(); run_frame(100);
        add_ev(55, 10, EV_RST, mk(0, 0, 0, 0, 0), 0);
        start_frame(); run_frame(100);
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

        nxt = mk(0, 0, 0, 1, 0);
        tick();
        rst = 1'b0;
        start_frame(); run_frame(43);
        chk("events_consumed", 32'(ev_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
